// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg
//   Shared types and helpers for the Booth multiplier scheduler.
//   - state_t   : scheduler FSM states.
//   - cnt_width : width of the iteration counter for a given number of
//                 multiplier cycles (must be able to hold MULT_CYCLES).
package booth_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
  } state_t;

  localparam int DEFAULT_MULT_CYCLES = 4;

  function automatic int cnt_width(input int mult_cycles);
    return $clog2(mult_cycles + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_MULT_CYCLES);

endpackage

// File: rtl/booth.sv
// booth
//   Sequential radix-2 Booth multiplier, one recoding step per clock.
//   A load pulse captures M and Q; WIDTH clocks later P holds the signed
//   product and stays there until the next load.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   load   in   start a new multiplication (captures M, Q)
//   M      in   WIDTH-bit signed multiplicand
//   Q      in   WIDTH-bit signed multiplier
//   P      out  2*WIDTH-bit signed product
module booth #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = $clog2(WIDTH + 1);

  // Accumulator carries one guard bit so that -M of the most negative
  // multiplicand (e.g. -(-8)) does not overflow.
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             q1_reg;
  logic [CW-1:0]    cnt_reg;

  assign m_ext = {m_reg[WIDTH-1], m_reg};

  always_comb begin
    sum = a_reg;
    case ({q_reg[0], q1_reg})
      2'b01:   sum = a_reg + m_ext;
      2'b10:   sum = a_reg - m_ext;
      default: sum = a_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q1_reg  <= 1'b0;
      cnt_reg <= '0;
    end else if (load) begin
      a_reg   <= '0;
      q_reg   <= Q;
      m_reg   <= M;
      q1_reg  <= 1'b0;
      cnt_reg <= CW'(WIDTH);
    end else if (cnt_reg != '0) begin
      // Arithmetic shift right of {A, Q, q-1} after the add/subtract.
      a_reg   <= {sum[WIDTH], sum[WIDTH:1]};
      q_reg   <= {sum[0], q_reg[WIDTH-1:1]};
      q1_reg  <= q_reg[0];
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  // The guard bit is only needed during the iterations; the final
  // 2*WIDTH-bit product fits in the low bits.
  assign P = {a_reg[WIDTH-1:0], q_reg};

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at
//   (last_grant + 1) mod NUM_REQ and picks the first active request.
//   The pointer itself lives in the caller.
// Ports:
//   req         in   per-requester request
//   last_grant  in   index of the most recent winner
//   enable      in   when low, no grant is issued
//   gnt         out  one-hot grant (all zero if nothing requested)
//   gnt_idx     out  encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic            found;
  int              pos;
  logic [ID_W-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    sel     = '0;
    // k = NUM_REQ wraps back to last_grant itself, so a lone requester
    // can win twice in a row.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      sel = ID_W'(pos);
      if (enable && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_sched.sv
// booth_mult_sched
//   Shares one sequential Booth multiplier between NUM_REQ requesters.
//   IDLE grants one requester round-robin, LOAD pulses the multiplier,
//   RUN waits out the iterations, CAPT samples the product and DONE
//   presents it on the response channel until the consumer takes it.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   per-requester request valid
//   req_m      in   packed multiplicands (slice i = requester i)
//   req_q      in   packed multipliers   (slice i = requester i)
//   req_ready  out  one-hot grant, only in IDLE
//   rsp_valid  out  response valid (DONE)
//   rsp_id     out  requester index owning the product
//   rsp_p      out  signed product
//   rsp_ready  in   consumer accepts the response
//   mul_load   out  multiplier load pulse
//   mul_m      out  multiplier M operand
//   mul_q      out  multiplier Q operand
//   mul_p      in   multiplier product
//   busy       out  FSM not in IDLE
module booth_mult_sched
  import booth_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 4,
  parameter int MULT_CYCLES = WIDTH,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_m,
  input  logic [NUM_REQ*WIDTH-1:0] req_q,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_p,
  input  logic                     rsp_ready,
  output logic                     mul_load,
  output logic [WIDTH-1:0]         mul_m,
  output logic [WIDTH-1:0]         mul_q,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     busy
);

  localparam int CNT_W = cnt_width(MULT_CYCLES);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ID_W-1:0]       last_grant_reg, last_grant_next;
  logic [ID_W-1:0]       id_reg, id_next;
  logic [WIDTH-1:0]      m_reg, m_next;
  logic [WIDTH-1:0]      q_reg, q_next;
  logic [2*WIDTH-1:0]    p_reg, p_next;

  logic [WIDTH-1:0]      m_arr [NUM_REQ];
  logic [WIDTH-1:0]      q_arr [NUM_REQ];

  logic                  arb_enable;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign m_arr[gi] = req_m[gi*WIDTH +: WIDTH];
      assign q_arr[gi] = req_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Reset is folded in so that no grant is shown while reset is held.
  assign arb_enable = (state_reg == S_IDLE) && reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .enable     (arb_enable),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // The arbiter only grants an active request, so any grant is an accept.
  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    m_next          = m_reg;
    q_next          = q_reg;
    p_next          = p_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          m_next          = m_arr[gnt_idx];
          q_next          = q_arr[gnt_idx];
          id_next         = gnt_idx;
          last_grant_next = gnt_idx;
          state_next      = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_next   = CNT_W'(MULT_CYCLES);
        state_next = S_RUN;
      end
      S_RUN: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = S_CAPT;
        end
      end
      S_CAPT: begin
        // Multiplier finished its last iteration on the previous edge.
        p_next     = mul_p;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      m_reg          <= '0;
      q_reg          <= '0;
      p_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      m_reg          <= m_next;
      q_reg          <= q_next;
      p_reg          <= p_next;
    end
  end

  assign mul_load  = (state_reg == S_LOAD);
  assign busy      = (state_reg != S_IDLE);
  assign rsp_valid = (state_reg == S_DONE);
  assign rsp_id    = id_reg;
  assign rsp_p     = p_reg;
  assign mul_m     = m_reg;
  assign mul_q     = q_reg;

endmodule

// File: tb/tb_booth_mult_sched.sv
// tb_booth_mult_sched
//   Scheduler and Booth multiplier back-to-back. Directed stimulus sets
//   hand-computed products; the negedge monitor predicts each grant with
//   a round-robin model, queues the expected response, and compares it
//   when the response handshake occurs.
module tb_booth_mult_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int MC      = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_m;
  logic [NUM_REQ*WIDTH-1:0] req_q;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_p;
  logic                     rsp_ready;
  logic                     mul_load;
  logic [WIDTH-1:0]         mul_m;
  logic [WIDTH-1:0]         mul_q;
  logic [2*WIDTH-1:0]       mul_p;
  logic                     busy;

  always #5 clk = ~clk;

  booth_mult_sched #(
    .NUM_REQ     (NUM_REQ),
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MC),
    .ID_W        (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_m     (req_m),
    .req_q     (req_q),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .mul_load  (mul_load),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  booth #(.WIDTH(WIDTH)) u_mult (
    .clk   (clk),
    .reset (reset),
    .load  (mul_load),
    .M     (mul_m),
    .Q     (mul_q),
    .P     (mul_p)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      p;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_p [NUM_REQ];
  int         model_last = NUM_REQ - 1;
  int         wait_cnt [NUM_REQ];
  int         max_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] m, input logic [3:0] q, input logic [7:0] p);
    req_m[i*WIDTH +: WIDTH] = m;
    req_q[i*WIDTH +: WIDTH] = q;
    exp_p[i] = p;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    if (busy || sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy=%0d pending=%0d required idle with none pending", tag, busy, sb.size());
    end
  endtask

  // Monitor: grant prediction, scoreboard push, response compare.
  always @(negedge clk) begin
    int   w;
    int   g;
    exp_t e;
    if (!reset) begin
      sb.delete();
      model_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    end else begin
      checks++;
      if (!$onehot0(req_ready)) begin
        failures++;
        $display("FAIL req_ready_onehot: got %b required at most one bit", req_ready);
      end
      if (req_ready != '0) begin
        w = rr_model(req_valid, model_last);
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        checks++;
        if (w < 0 || req_ready !== (NUM_REQ'(1) << w)) begin
          failures++;
          $display("FAIL grant: got req_ready=%b valid=%b expected winner %0d", req_ready, req_valid, w);
        end
        if (w >= 0) begin
          e.id = w[ID_W-1:0];
          e.p  = exp_p[w];
          sb.push_back(e);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i == w) wait_cnt[i] = 0;
            else if (req_valid[i]) begin
              wait_cnt[i]++;
              if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end else wait_cnt[i] = 0;
          end
          model_last = w;
        end
        grant_log.push_back(g);
        $display("accept: grant=%0d valid=%b expect_p=%02h", g, req_valid, exp_p[(w < 0) ? 0 : w]);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got id=%0d p=%02h required no response", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_p !== e.p) begin
            failures++;
            $display("FAIL rsp: got id=%0d p=%02h required id=%0d p=%02h", rsp_id, rsp_p, e.id, e.p);
          end else begin
            $display("response: id=%0d p=%02h", rsp_id, rsp_p);
          end
        end
      end
    end
  end

  // One request on requester id, checking the cycle-by-cycle timing.
  task automatic run_single(input string tag, input int id, input logic [3:0] m,
                            input logic [3:0] q, input logic [7:0] p);
    set_req(id, m, q, p);
    req_valid = NUM_REQ'(1) << id;
    #1;
    check({tag, "_ready"}, req_ready, NUM_REQ'(1) << id);
    for (int c = 1; c <= MC + 3; c++) begin
      cyc();
      if (c == 1) req_valid = '0;
      check($sformatf("%s_load_c%0d", tag, c), mul_load, (c == 1));
      check($sformatf("%s_valid_c%0d", tag, c), rsp_valid, (c == MC + 3));
      check($sformatf("%s_busy_c%0d", tag, c), busy, 1);
    end
    wait_idle(tag);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int start;
    int n;
    reset     = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_q     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) exp_p[i] = '0;
    repeat (3) cyc();
    check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_p, mul_load, mul_m, mul_q, busy}, 0);
    reset = 1'b1;
    cyc();

    // Single request and corner operands.
    run_single("single",   0, 4'h3, 4'hE, 8'hFA);
    run_single("neg8neg8", 1, 4'h8, 4'h8, 8'h40);
    run_single("p7neg8",   2, 4'h7, 4'h8, 8'hC8);
    run_single("zero",     3, 4'h0, 4'h5, 8'h00);

    // All requesters active: grant order 0,1,2,3,0.
    start = grant_log.size();
    set_req(0, 4'h2, 4'h3, 8'h06);
    set_req(1, 4'hD, 4'h4, 8'hF4);
    set_req(2, 4'h5, 4'hB, 8'hE7);
    set_req(3, 4'hF, 4'h9, 8'h07);
    req_valid = 4'hF;
    n = 0;
    while (grant_log.size() < start + 5 && n < 200) begin
      cyc();
      n++;
    end
    req_valid = '0;
    check("allreq_grants", grant_log.size() - start, 5);
    for (int k = 0; k < 5; k++) begin
      if (start + k < grant_log.size())
        check($sformatf("allreq_order%0d", k), grant_log[start + k], order[k]);
    end
    wait_idle("allreq");

    // Backpressure in DONE.
    rsp_ready = 1'b0;
    set_req(1, 4'h9, 4'h3, 8'hEB);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      cyc();
      n++;
    end
    set_req(2, 4'h1, 4'h1, 8'h01);
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("bp_valid%0d", k), rsp_valid, 1);
      check($sformatf("bp_id%0d", k), rsp_id, 1);
      check($sformatf("bp_p%0d", k), rsp_p, 8'hEB);
      check($sformatf("bp_ready%0d", k), req_ready, 0);
      check($sformatf("bp_load%0d", k), mul_load, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    #1;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    check("bp_next_load", mul_load, 1);
    wait_idle("bp");

    // Reset mid-RUN.
    set_req(2, 4'hC, 4'h6, 8'hE8);
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst_run_outputs", {req_ready, rsp_valid, rsp_id, rsp_p, mul_load, mul_m, mul_q, busy}, 0);
    set_req(3, 4'h6, 4'h2, 8'h0C);
    req_valid = 4'b1100;
    #1;
    check("rst_ready_low", req_ready, 0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("rst_prio", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    check("rst_load", mul_load, 1);
    wait_idle("rst");

    // Random soak.
    for (int it = 0; it < 1000; it++) begin
      logic [3:0]        mv;
      logic [3:0]        qv;
      logic signed [7:0] me;
      logic signed [7:0] qe;
      logic signed [7:0] pm;
      for (int i = 0; i < NUM_REQ; i++) begin
        mv = 4'($urandom_range(0, 15));
        qv = 4'($urandom_range(0, 15));
        me = {{4{mv[3]}}, mv};
        qe = {{4{qv[3]}}, qv};
        pm = me * qe;
        set_req(i, mv, qv, pm);
      end
      req_valid = NUM_REQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("soak");
    check("sb_empty", sb.size(), 0);
    check("max_wait", (max_wait <= NUM_REQ - 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_sched.md
# booth_mult_sched

Round-robin scheduler that shares one 4-bit radix-2 Booth multiplier (`booth`) between several requesters. Each requester presents a signed operand pair with a valid/ready handshake. The scheduler grants one requester and sequences the multiplier's `load` pulse and iteration window. It then captures the 8-bit product and returns it with the requester ID over a single response channel. It sits between the request clients and the multiplier instance, and is the only driver of the multiplier's `load`, `M` and `Q` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 4: operand width; must match the multiplier.
- `MULT_CYCLES`, default 4 (= `WIDTH`): multiplier iteration cycles after the load edge.
- `ID_W`, default `$clog2(NUM_REQ)`: response ID width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_m`  in  `NUM_REQ*WIDTH`  multiplicands; slice i belongs to requester i; two's complement.
- `req_q`  in  `NUM_REQ*WIDTH`  multipliers, same packing.
- `req_ready`  out  `NUM_REQ`  one-hot grant; at most one bit high.
- `rsp_valid`  out  1  product valid.
- `rsp_id`  out  `ID_W`  index of the requester that owns the product.
- `rsp_p`  out  `2*WIDTH`  signed product.
- `rsp_ready`  in  1  consumer accepts the response.
- `mul_load`  out  1  to multiplier `load`.
- `mul_m`  out  `WIDTH`  to multiplier `M`.
- `mul_q`  out  `WIDTH`  to multiplier `Q`.
- `mul_p`  in  `2*WIDTH`  from multiplier `P`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, LOAD, RUN, CAPT and DONE.
- **IDLE:** the round-robin arbiter examines `req_valid` starting at `(last_grant+1) mod NUM_REQ`. The winner's `req_ready` is asserted combinationally, in IDLE only.
- **Accept:** on `req_valid[i] & req_ready[i]`, register `req_m[i]`, `req_q[i]` and `i`, set `last_grant <= i`, and go to LOAD.
- **No request:** with no valid request, stay in IDLE with all `req_ready` low.
- **LOAD:** `mul_load=1` for exactly one cycle. `mul_m`/`mul_q` present the latched operands and hold them until the next accept. Load `cnt <= MULT_CYCLES`, then go to RUN.
- **RUN:** `mul_load=0`; decrement `cnt` each cycle. When `cnt==1`, go to CAPT.
- **CAPT:** register `rsp_p <= mul_p`, since the multiplier is now holding its final result; then go to DONE.
- **DONE:** `rsp_valid=1`, and `rsp_id`/`rsp_p` are stable. On `rsp_ready`, go to IDLE. Otherwise hold indefinitely (backpressure).
- **Request inputs:** ignored outside IDLE. A requester's `req_valid` may drop before grant with no effect.
- **Arithmetic:** the product is signed `WIDTH×WIDTH → 2*WIDTH` with no saturation. The scheduler does not compute it; it only forwards `mul_p`.
- **Reset (asynchronous, any state, including mid-RUN):**
  - state → IDLE, `cnt=0`, `last_grant=NUM_REQ-1` (requester 0 has first priority).
  - all outputs low or zero: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_p`, `mul_load`, `mul_m`, `mul_q`, `busy`.
  - an in-flight product is discarded and no response is issued.
  - the multiplier has its own reset; the scheduler does not drive it.

## Timing
- Accept in cycle 0 → `mul_load` high in cycle 1 → RUN in cycles 2..`MULT_CYCLES+1` → CAPT in cycle `MULT_CYCLES+2` → `rsp_valid` from cycle `MULT_CYCLES+3`. With defaults this is cycle 7.
- Throughput is at best one product per `MULT_CYCLES+4` cycles: the DONE→IDLE cycle, then a new accept.
- `rsp_ready` asserted in the first DONE cycle costs no extra cycles. The next accept can occur one cycle after the DONE handshake.
- `mul_load` decodes directly from the state register and is glitch-free relative to `clk`. All other outputs are registered, except `req_ready`, which is combinational from `req_valid`, state and `last_grant`.
- **Simultaneous requests:** the highest rotated priority wins; the losers keep `req_valid` high and win on later rounds. No requester waits more than `NUM_REQ-1` grants.
- **Pointer wrap:** after `last_grant = NUM_REQ-1`, requester 0 has top priority.

## Structure
- Package `booth_sched_pkg`: state enum (`S_IDLE`, `S_LOAD`, `S_RUN`, `S_CAPT`, `S_DONE`) and a counter width constant derived from `MULT_CYCLES`.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - inputs: `req`, `last_grant`, `enable`.
  - output: one-hot `gnt` plus encoded index.
  - purely combinational; the pointer register stays in the top level.
- The bench instantiates `booth_mult_sched` and `booth` back-to-back and uses a behavioural signed multiply as the reference model.

## Test plan
- **Single request:** `req_valid=4'b0001`, m=3, q=−2 → `mul_load` pulse in cycle 1; `rsp_valid` in cycle 7 with `rsp_id=0`, `rsp_p=8'hFA`.
- **Corner operands:** m=−8, q=−8 → `8'h40`; m=7, q=−8 → `8'hC8`; m=0, q=5 → `8'h00`.
- **All requesters active:** all four hold `req_valid` with distinct operands → grant order 0, 1, 2, 3, 0; each product matches the model; `req_ready` is one-hot.
- **Backpressure:** hold `rsp_ready=0` for 10 cycles in DONE → `rsp_valid`, `rsp_p` and `rsp_id` stay stable, `req_ready` stays 0, and no second `mul_load` is issued; release → return to IDLE the next cycle.
- **Reset mid-RUN:** assert `reset=0` in cycle 3 → all outputs 0 immediately (asynchronously); after release, a new request to requester 2 is granted with requester 0 priority restored, and a correct product is returned.
- **Random soak:** 1000 random request patterns and `rsp_ready` patterns → every accepted request yields exactly one correct response with the matching ID, and no starvation beyond `NUM_REQ-1` grants.
